// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants for the EX->MEM pipeline register: default bus widths,
// idle memory-op code, reset level and zero constants.
package ex_mem_pipe_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_MEMRW_W = 2;
  localparam int DEF_CNT_W   = 16;

  localparam logic RST_ACTIVE = 1'b0;

  localparam logic [DEF_MEMRW_W-1:0] MEMRW_IDLE = '0;
  localparam logic [DEF_DATA_W-1:0]  DATA_ZERO  = '0;
  localparam logic [DEF_ADDR_W-1:0]  ADDR_ZERO  = '0;
  localparam logic [DEF_REG_AW-1:0]  REGA_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM handshake bundle: EX-side request, MEM-side response and forwarding taps.
interface ex_mem_pipe_if
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int MEMRW_W = DEF_MEMRW_W
) ();

  logic               ex_valid;
  logic               ex_ready;
  logic [MEMRW_W-1:0] ex_memrw;
  logic [ADDR_W-1:0]  ex_memaddr;
  logic [DATA_W-1:0]  ex_memdata;
  logic [DATA_W-1:0]  ex_wdata;
  logic [REG_AW-1:0]  ex_waddr;
  logic               ex_we;

  logic               mem_valid;
  logic               mem_ready;
  logic [MEMRW_W-1:0] mem_memrw;
  logic [ADDR_W-1:0]  mem_memaddr;
  logic [DATA_W-1:0]  mem_memdata;
  logic [DATA_W-1:0]  mem_wdata;
  logic [REG_AW-1:0]  mem_waddr;
  logic               mem_we;

  logic               fwd_we;
  logic [REG_AW-1:0]  fwd_waddr;
  logic [DATA_W-1:0]  fwd_wdata;

  modport master (
    output ex_valid, ex_memrw, ex_memaddr, ex_memdata, ex_wdata, ex_waddr, ex_we,
    output mem_ready,
    input  ex_ready,
    input  mem_valid, mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we,
    input  fwd_we, fwd_waddr, fwd_wdata
  );

  modport slave (
    input  ex_valid, ex_memrw, ex_memaddr, ex_memdata, ex_wdata, ex_waddr, ex_we,
    input  mem_ready,
    output ex_ready,
    output mem_valid, mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we,
    output fwd_we, fwd_waddr, fwd_wdata
  );

endinterface

// File: rtl/ex_mem_pipe_skid_reg.sv
// Generic two-entry skid buffer: output register M plus skid register S, with
// a registered input-ready so no combinational path runs from i_ready to o_ready.
module pipe_skid_reg
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_e  r_state;
  logic         r_ready;
  logic         r_valid;
  logic [W-1:0] r_m_data;
  logic [W-1:0] r_s_data;
  logic         w_acc;
  logic         w_con;

  assign w_acc = i_valid & r_ready;
  assign w_con = r_valid & i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_EMPTY;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_m_data <= '0;
      r_s_data <= '0;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_m_data <= i_data;
            r_valid  <= 1'b1;
            r_state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_con) begin
            r_m_data <= i_data;
          end else if (w_acc) begin
            // MEM stalled: park the new entry in S and close the input
            r_s_data <= i_data;
            r_ready  <= 1'b0;
            r_state  <= ST_FULL;
          end else if (w_con) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_con) begin
            r_m_data <= r_s_data;
            r_ready  <= 1'b1;
            r_state  <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_m_data;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: skid-buffered payload, bubble masking,
// forwarding of the head entry's writeback and a saturating stall counter.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int MEMRW_W = DEF_MEMRW_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_mem_pipe_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int W = MEMRW_W + ADDR_W + 2 * DATA_W + REG_AW + 1;

  logic [W-1:0]       w_in;
  logic [W-1:0]       w_head;
  logic               w_vld;
  logic               w_ex_ready;
  logic [MEMRW_W-1:0] w_memrw;
  logic [ADDR_W-1:0]  w_memaddr;
  logic [DATA_W-1:0]  w_memdata;
  logic [DATA_W-1:0]  w_wdata;
  logic [REG_AW-1:0]  w_waddr;
  logic               w_we;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign w_in = {bus.ex_memrw, bus.ex_memaddr, bus.ex_memdata,
                 bus.ex_wdata, bus.ex_waddr, bus.ex_we};

  pipe_skid_reg #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_valid (bus.ex_valid),
    .o_ready (w_ex_ready),
    .i_data  (w_in),
    .o_valid (w_vld),
    .i_ready (bus.mem_ready),
    .o_data  (w_head)
  );

  assign {w_memrw, w_memaddr, w_memdata, w_wdata, w_waddr, w_we} = w_head;

  // Control fields are forced idle on bubbles; address/data pass through
  assign bus.ex_ready    = w_ex_ready;
  assign bus.mem_valid   = w_vld;
  assign bus.mem_memrw   = w_vld ? w_memrw : '0;
  assign bus.mem_we      = w_vld & w_we;
  assign bus.mem_memaddr = w_memaddr;
  assign bus.mem_memdata = w_memdata;
  assign bus.mem_wdata   = w_wdata;
  assign bus.mem_waddr   = w_waddr;

  assign bus.fwd_we    = w_vld & w_we;
  assign bus.fwd_waddr = w_waddr;
  assign bus.fwd_wdata = w_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_vld && !bus.mem_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: table-driven cycle vectors plus hand sequences,
// with a queue scoreboard tracking every accepted entry to its delivery.
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ex_mem_pipe_if bus ();

  ex_mem_pipe #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  memrw;
    logic [31:0] memaddr;
    logic [31:0] memdata;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        we;
  } pay_t;

  typedef struct packed {
    logic        v;
    logic        r;
    logic        f;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_mv;
    logic [4:0]  e_wa;
    logic [3:0]  e_cnt;
  } vec_t;

  pay_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    bus.ex_valid   = v;
    bus.mem_ready  = r;
    flush          = f;
    bus.ex_waddr   = wa;
    bus.ex_wdata   = wd;
    bus.ex_we      = we;
    bus.ex_memrw   = wa[1:0];
    bus.ex_memaddr = 32'h1000 + {25'h0, wa, 2'b00};
    bus.ex_memdata = ~wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pay_t cur_in();
    return '{bus.ex_memrw, bus.ex_memaddr, bus.ex_memdata, bus.ex_wdata, bus.ex_waddr, bus.ex_we};
  endfunction

  function automatic pay_t cur_out();
    return '{bus.mem_memrw, bus.mem_memaddr, bus.mem_memdata, bus.mem_wdata, bus.mem_waddr, bus.mem_we};
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so decisions made
  // here describe what the next rising edge will do.
  always @(negedge clk) begin
    if (rst != RST_ACTIVE) begin
      chk("sb_valid", 128'(bus.mem_valid), 128'(q.size() != 0));
      if (bus.mem_valid && q.size() != 0)
        chk("sb_head", 128'(cur_out()), 128'(q[0]));
      if (flush) begin
        q.delete();
      end else begin
        if (bus.mem_valid && bus.mem_ready && q.size() != 0) void'(q.pop_front());
        if (bus.ex_valid && bus.ex_ready) q.push_back(cur_in());
      end
    end
  end

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'd1,  32'h11, 1'b1, 1'b1, 5'd1,  4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'd2,  32'h22, 1'b1, 1'b1, 5'd2,  4'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h33, 1'b1, 1'b1, 5'd3,  4'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 5'd4,  32'h44, 1'b1, 1'b1, 5'd4,  4'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  4'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd10, 32'hA0, 1'b1, 1'b1, 5'd10, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd11, 32'hB0, 1'b0, 1'b1, 5'd10, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'd12, 32'hC0, 1'b0, 1'b1, 5'd10, 4'd2};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd12, 32'hC0, 1'b0, 1'b1, 5'd10, 4'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'd12, 32'hC0, 1'b1, 1'b1, 5'd11, 4'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 5'd12, 32'hC0, 1'b1, 1'b1, 5'd12, 4'd3};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  4'd3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'd20, 32'h200, 1'b1, 1'b1, 5'd20, 4'd3};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'd21, 32'h210, 1'b0, 1'b1, 5'd20, 4'd4};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 5'd22, 32'h220, 1'b1, 1'b0, 5'd0,  4'd5};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  4'd5};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 5'd23, 32'h230, 1'b1, 1'b1, 5'd23, 4'd5};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  4'd5};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 5'd24, 32'h240, 1'b1, 1'b1, 5'd24, 4'd5};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 5'd25, 32'h250, 1'b1, 1'b0, 5'd0,  4'd6};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  4'd6};

    rst = RST_ACTIVE;
    drive(1'b0, 1'b0, 1'b0, REGA_ZERO, DATA_ZERO, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_ready",  128'(bus.ex_ready),  128'(1'b1));
    chk("rst_mem_valid", 128'(bus.mem_valid), 128'(1'b0));
    chk("rst_mem_we",    128'(bus.mem_we),    128'(1'b0));
    chk("rst_memrw",     128'(bus.mem_memrw), 128'(MEMRW_IDLE));
    chk("rst_fwd_we",    128'(bus.fwd_we),    128'(1'b0));
    chk("rst_stall_cnt", 128'(stall_cnt),     128'(4'd0));
    #2 rst = ~RST_ACTIVE;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].wa, tbl[i].wd, 1'b1);
      step();
      chk($sformatf("row%0d_ex_ready", i),  128'(bus.ex_ready),  128'(tbl[i].e_rdy));
      chk($sformatf("row%0d_mem_valid", i), 128'(bus.mem_valid), 128'(tbl[i].e_mv));
      chk($sformatf("row%0d_stall_cnt", i), 128'(stall_cnt),     128'(tbl[i].e_cnt));
      if (tbl[i].e_mv) begin
        chk($sformatf("row%0d_waddr", i), 128'(bus.mem_waddr), 128'(tbl[i].e_wa));
        chk($sformatf("row%0d_we", i),    128'(bus.mem_we),    128'(1'b1));
      end else begin
        chk($sformatf("row%0d_bub_we", i),    128'(bus.mem_we),    128'(1'b0));
        chk($sformatf("row%0d_bub_memrw", i), 128'(bus.mem_memrw), 128'(2'b00));
        chk($sformatf("row%0d_bub_fwd", i),   128'(bus.fwd_we),    128'(1'b0));
      end
    end

    // Forwarding of a held entry
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      chk($sformatf("fwd%0d_we", k),    128'(bus.fwd_we),    128'(1'b1));
      chk($sformatf("fwd%0d_waddr", k), 128'(bus.fwd_waddr), 128'(5'd5));
      chk($sformatf("fwd%0d_wdata", k), 128'(bus.fwd_wdata), 128'(32'hDEADBEEF));
    end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    chk("fwd_after_we",    128'(bus.fwd_we),    128'(1'b0));
    chk("fwd_after_valid", 128'(bus.mem_valid), 128'(1'b0));

    // Asynchronous reset while FULL
    drive(1'b1, 1'b0, 1'b0, 5'd6, 32'h66, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 1'b1);
    step();
    chk("full_ex_ready", 128'(bus.ex_ready), 128'(1'b0));
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    rst = RST_ACTIVE;
    q.delete();
    #1;
    chk("arst_mem_valid", 128'(bus.mem_valid),   128'(1'b0));
    chk("arst_ex_ready",  128'(bus.ex_ready),    128'(1'b1));
    chk("arst_mem_we",    128'(bus.mem_we),      128'(1'b0));
    chk("arst_memrw",     128'(bus.mem_memrw),   128'(2'b00));
    chk("arst_memaddr",   128'(bus.mem_memaddr), 128'(ADDR_ZERO));
    chk("arst_fwd_we",    128'(bus.fwd_we),      128'(1'b0));
    chk("arst_fwd_waddr", 128'(bus.fwd_waddr),   128'(REGA_ZERO));
    chk("arst_fwd_wdata", 128'(bus.fwd_wdata),   128'(DATA_ZERO));
    chk("arst_stall_cnt", 128'(stall_cnt),       128'(4'd0));
    @(posedge clk);
    #3 rst = ~RST_ACTIVE;

    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h88, 1'b1);
    step();
    chk("post_rst_valid", 128'(bus.mem_valid), 128'(1'b1));
    chk("post_rst_waddr", 128'(bus.mem_waddr), 128'(5'd8));
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    step();

    // Counter saturation
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 1'b1);
    step();
    chk("sat_start", 128'(stall_cnt), 128'(4'd0));
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) chk("sat_14", 128'(stall_cnt), 128'(4'd14));
      if (k == 15) chk("sat_15", 128'(stall_cnt), 128'(4'd15));
    end
    chk("sat_20", 128'(stall_cnt), 128'(4'd15));
    repeat (3) step();
    chk("sat_hold", 128'(stall_cnt), 128'(4'd15));
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    chk("sat_drain_valid", 128'(bus.mem_valid), 128'(1'b0));
    chk("sat_drain_cnt",   128'(stall_cnt),     128'(4'd15));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
